// File: rtl/uart_msg_pkg.sv
// Shared types and constants for the UART message sequencer.
// Define UART_MSG_CRLF_EN to end every message with CR LF instead of LF.
package uart_msg_pkg;

   localparam logic [2:0] COL_RED   = 3'b100;
   localparam logic [2:0] COL_BLUE  = 3'b001;
   localparam logic [2:0] COL_GREEN = 3'b010;

   localparam logic [7:0] ASCII_LF   = 8'h0A;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_DASH = 8'h2D;
   localparam logic [7:0] ASCII_HASH = 8'h23;
   localparam logic [7:0] ASCII_EQ   = 8'h3D;
   localparam logic [7:0] ASCII_0    = 8'h30;

`ifdef UART_MSG_CRLF_EN
   localparam logic [4:0] TERM_LEN = 5'd2;
`else
   localparam logic [4:0] TERM_LEN = 5'd1;
`endif

   typedef enum logic [1:0] {
      EVT_RED,
      EVT_BLUE,
      EVT_GREEN,
      EVT_NODE
   } evt_kind_e;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      START,
      WAIT
   } state_e;

   typedef struct packed {
      evt_kind_e  kind;
      logic [6:0] val;
   } evt_t;

   function automatic logic [4:0] body_len(evt_t e);
      if (e.kind != EVT_NODE) return 5'd13;
      return (e.val >= 7'd10) ? 5'd7 : 5'd6;
   endfunction

   function automatic logic [4:0] last_idx(evt_t e);
      return body_len(e) + TERM_LEN - 5'd1;
   endfunction

   function automatic logic [7:0] msg_char(evt_t e, logic [4:0] idx);
      logic [4:0] blen;
      logic [6:0] tens;
      logic [6:0] ones;
      logic [7:0] c;
      blen = body_len(e);
      tens = e.val / 7'd10;
      ones = e.val - tens * 7'd10;
      c    = ASCII_LF;
      if (idx >= blen) begin
         if (idx == blen && TERM_LEN == 5'd2) c = ASCII_CR;
      end else if (e.kind == EVT_NODE) begin
         case (idx)
            5'd0:    c = "N";
            5'd1:    c = "O";
            5'd2:    c = "D";
            5'd3:    c = "E";
            5'd4:    c = ASCII_EQ;
            5'd5:    c = ASCII_0 + {1'b0, (e.val >= 7'd10) ? tens : ones};
            default: c = ASCII_0 + {1'b0, ones};
         endcase
      end else begin
         case (idx)
            5'd0:    c = "S";
            5'd1:    c = "L";
            5'd2:    c = "M";
            5'd3:    c = ASCII_DASH;
            5'd4:    c = "F";
            5'd5:    c = "S";
            5'd6:    c = "U";
            5'd7:    c = (e.kind == EVT_RED)  ? "2" :
                         (e.kind == EVT_BLUE) ? "3" : "1";
            5'd8:    c = ASCII_DASH;
            5'd9:    c = (e.kind == EVT_GREEN) ? "A" : "I";
            5'd10:   c = (e.kind == EVT_RED) ? "M" : "S";
            5'd11:   c = ASCII_DASH;
            default: c = ASCII_HASH;
         endcase
      end
      return c;
   endfunction

endpackage

// File: rtl/uart_msg_seq_if.sv
// Byte handshake between the message sequencer and a UART transmitter.
interface uart_msg_seq_if;

   logic       tx_start;
   logic [7:0] msg;
   logic       tx_done;

   modport master (
      output tx_start,
      output msg,
      input  tx_done
   );

   modport slave (
      input  tx_start,
      input  msg,
      output tx_done
   );

endinterface

// File: rtl/uart_msg_evt_fifo.sv
// Event queue: synchronous FIFO with two ordered write ports and one read port.
// Port 0 always takes the first free slot, so a same-cycle pair keeps port 0.
module uart_msg_evt_fifo
   import uart_msg_pkg::*;
#(
   parameter int EVT_DEPTH = 4
) (
   input  logic clk_3125KHz,
   input  logic rst,
   input  logic wr0_en,
   input  evt_t wr0_data,
   input  logic wr1_en,
   input  evt_t wr1_data,
   input  logic rd_en,
   output evt_t rd_data,
   output logic full,
   output logic empty,
   output logic drop
);

   localparam int AW = $clog2(EVT_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(EVT_DEPTH);

   evt_t          mem [EVT_DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW:0]   cnt;
   logic [AW:0]   room;
   logic          do_rd;
   logic          acc0;
   logic          acc1;

   assign full    = (cnt == DEPTH_C);
   assign empty   = (cnt == '0);
   assign rd_data = mem[rp];

   // A pop in the same cycle frees a slot for an incoming write.
   always_comb begin
      do_rd = rd_en && !empty;
      room  = DEPTH_C - cnt + {{AW{1'b0}}, do_rd};
      acc0  = wr0_en && (room != '0);
      acc1  = wr1_en &&
              (acc0 ? (room > (AW+1)'(1)) : (room != '0));
      drop  = (wr0_en && !acc0) || (wr1_en && !acc1);
   end

   always_ff @(posedge clk_3125KHz) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (acc0) mem[wp] <= wr0_data;
         if (acc1) mem[acc0 ? wp + AW'(1) : wp] <= wr1_data;
         wp  <= wp + AW'(acc0) + AW'(acc1);
         if (do_rd) rp <= rp + AW'(1);
         cnt <= cnt + (AW+1)'(acc0) + (AW+1)'(acc1)
                - (AW+1)'(do_rd);
      end
   end

endmodule

// File: rtl/uart_msg_seq.sv
// Turns color/node events into ASCII messages sent byte by byte to a UART.
// Terminator is LF, or CR LF when UART_MSG_CRLF_EN is defined.
module uart_msg_seq
   import uart_msg_pkg::*;
#(
   parameter int NODE_W    = 4,
   parameter int EVT_DEPTH = 4
) (
   input  logic              clk_3125KHz,
   input  logic              rst,
   input  logic              color_valid,
   input  logic [2:0]        detected_color,
   input  logic              node_valid,
   input  logic [NODE_W-1:0] node,
   output logic              busy,
   output logic              overflow,
   uart_msg_seq_if.master    tx
);

   state_e     state;
   logic [4:0] idx;
   evt_t       cur;

   logic       col_ok;
   evt_kind_e  col_kind;
   logic [6:0] node_cap;

   logic       col_pend;
   logic       node_pend;
   evt_t       col_evt;
   evt_t       node_evt;

   evt_t       head;
   logic       rd_en;
   logic       full;
   logic       empty;
   logic       drop;

   always_comb begin
      col_ok   = 1'b1;
      col_kind = EVT_RED;
      unique case (1'b1)
         (detected_color == COL_RED):   col_kind = EVT_RED;
         (detected_color == COL_BLUE):  col_kind = EVT_BLUE;
         (detected_color == COL_GREEN): col_kind = EVT_GREEN;
         default:                       col_ok   = 1'b0;
      endcase
   end

   always_comb begin
      node_cap = (32'(node) > 32'd99) ? 7'd99 : 7'(node);
   end

   // Payload is captured at the strobe; the queue write follows a cycle later.
   always_ff @(posedge clk_3125KHz) begin
      if (rst) begin
         col_pend  <= 1'b0;
         node_pend <= 1'b0;
         col_evt   <= '0;
         node_evt  <= '0;
      end else begin
         col_pend  <= color_valid && col_ok;
         node_pend <= node_valid;
         if (color_valid) col_evt  <= '{kind: col_kind, val: 7'd0};
         if (node_valid)  node_evt <= '{kind: EVT_NODE, val: node_cap};
      end
   end

   uart_msg_evt_fifo #(
      .EVT_DEPTH (EVT_DEPTH)
   ) u_fifo (
      .clk_3125KHz (clk_3125KHz),
      .rst         (rst),
      .wr0_en      (col_pend),
      .wr0_data    (col_evt),
      .wr1_en      (node_pend),
      .wr1_data    (node_evt),
      .rd_en       (rd_en),
      .rd_data     (head),
      .full        (full),
      .empty       (empty),
      .drop        (drop)
   );

   assign rd_en = (state == IDLE) && !empty;
   assign busy  = (state != IDLE) || !empty || full;

   always_ff @(posedge clk_3125KHz) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= 5'd0;
         cur         <= '0;
         tx.tx_start <= 1'b0;
         tx.msg      <= 8'h00;
         overflow    <= 1'b0;
      end else begin
         if (drop) overflow <= 1'b1;
         tx.tx_start <= 1'b0;
         unique case (state)
            IDLE: begin
               idx <= 5'd0;
               if (!empty) begin
                  cur   <= head;
                  state <= LOAD;
               end
            end
            LOAD: begin
               tx.msg      <= msg_char(cur, idx);
               tx.tx_start <= 1'b1;
               state       <= START;
            end
            START: state <= WAIT;
            WAIT: begin
               if (tx.tx_done) begin
                  if (idx == last_idx(cur)) begin
                     state <= IDLE;
                  end else begin
                     idx   <= idx + 5'd1;
                     state <= LOAD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_msg_seq.sv
// Self-checking bench for uart_msg_seq: a UART model answers each
// tx_start with tx_done and a byte scoreboard checks every transmitted byte.
module tb_uart_msg_seq;

   logic       clk_3125KHz = 1'b0;
   logic       rst = 1'b1;
   logic       color_valid = 1'b0;
   logic [2:0] detected_color = 3'b000;
   logic       node_valid = 1'b0;
   logic [6:0] node = 7'd0;
   logic       busy;
   logic       overflow;

   uart_msg_seq_if tx ();

   uart_msg_seq #(
      .NODE_W    (7),
      .EVT_DEPTH (4)
   ) dut (
      .clk_3125KHz    (clk_3125KHz),
      .rst            (rst),
      .color_valid    (color_valid),
      .detected_color (detected_color),
      .node_valid     (node_valid),
      .node           (node),
      .busy           (busy),
      .overflow       (overflow),
      .tx             (tx)
   );

   always #5 clk_3125KHz = ~clk_3125KHz;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   bit         hold_done = 1'b0;
   int         cyc = 0;
   bit         pend_done = 1'b0;
   int         pend_cyc = 0;
   int         done_cyc = 0;
   bit         prev_mid = 1'b0;
   logic [7:0] last_msg = 8'h00;

   function automatic void push_term();
`ifdef UART_MSG_CRLF_EN
      exp_q.push_back(8'h0D);
`endif
      exp_q.push_back(8'h0A);
   endfunction

   function automatic void exp_color(input logic [2:0] c);
      string s;
      case (c)
         3'b100:  s = "SLM-FSU2-IM-#";
         3'b001:  s = "SLM-FSU3-IS-#";
         3'b010:  s = "SLM-FSU1-AS-#";
         default: s = "";
      endcase
      if (s.len() == 0) return;
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      push_term();
   endfunction

   function automatic void exp_node(input int n);
      string s;
      s = $sformatf("NODE=%0d", (n > 99) ? 99 : n);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      push_term();
   endfunction

   // UART model and byte scoreboard, all on the falling edge.
   initial begin
      logic [7:0] e;
      tx.tx_done = 1'b0;
      forever begin
         @(negedge clk_3125KHz);
         cyc++;
         tx.tx_done = 1'b0;
         if (rst) begin
            pend_done = 1'b0;
            prev_mid  = 1'b0;
         end else begin
            if (pend_done && !hold_done && cyc >= pend_cyc + 2) begin
               checks++;
               if (tx.msg !== last_msg) begin
                  errors++;
                  $display("FAIL msg_stable: got %h want %h", tx.msg, last_msg);
               end
               tx.tx_done = 1'b1;
               pend_done  = 1'b0;
               done_cyc   = cyc;
            end
            if (tx.tx_start) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_byte: got %h want none", tx.msg);
               end else begin
                  e = exp_q.pop_front();
                  if (tx.msg !== e) begin
                     errors++;
                     $display("FAIL byte: got %h want %h", tx.msg, e);
                  end
                  if (prev_mid) begin
                     checks++;
                     if (cyc - done_cyc != 2) begin
                        errors++;
                        $display("FAIL gap: got %0d want 2", cyc - done_cyc);
                     end
                  end
                  prev_mid = (e != 8'h0A);
               end
               last_msg  = tx.msg;
               pend_done = 1'b1;
               pend_cyc  = cyc;
            end
         end
      end
   end

   task automatic strobe(input bit cv, input logic [2:0] code,
                         input bit nv, input logic [6:0] n);
      color_valid    = cv;
      detected_color = code;
      node_valid     = nv;
      node           = n;
      if (cv) exp_color(code);
      if (nv) exp_node(int'(n));
      @(negedge clk_3125KHz);
      color_valid    = 1'b0;
      node_valid     = 1'b0;
      detected_color = 3'b100;
      node           = 7'd88;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      repeat (4) @(negedge clk_3125KHz);
      while ((exp_q.size() != 0 || busy || pend_done) && n < 3000) begin
         @(negedge clk_3125KHz);
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_drain: busy %b left %0d, want busy 0 left 0",
                  name, busy, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk_3125KHz);
      checks += 4;
      if (tx.tx_start !== 1'b0) begin
         errors++; $display("FAIL rst_tx_start: got %b want 0", tx.tx_start);
      end
      if (tx.msg !== 8'h00) begin
         errors++; $display("FAIL rst_msg: got %h want 00", tx.msg);
      end
      if (busy !== 1'b0) begin
         errors++; $display("FAIL rst_busy: got %b want 0", busy);
      end
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL rst_overflow: got %b want 0", overflow);
      end
      rst = 1'b0;
      @(negedge clk_3125KHz);
   endtask

   task automatic test_red_latency();
      int k = 1;
      strobe(1'b1, 3'b100, 1'b0, 7'd0);
      while (!tx.tx_start && k < 20) begin
         @(negedge clk_3125KHz);
         k++;
      end
      checks++;
      if (k != 4) begin
         errors++; $display("FAIL first_latency: got %0d want 4", k);
      end
      wait_idle("red");
   endtask

   task automatic test_node();
      int vals[9] = '{7, 12, 15, 0, 9, 10, 99, 100, 120};
      foreach (vals[i]) begin
         strobe(1'b0, 3'b000, 1'b1, 7'(vals[i]));
         wait_idle("node");
      end
   endtask

   task automatic test_pair();
      strobe(1'b1, 3'b001, 1'b1, 7'd3);
      wait_idle("pair");
   endtask

   task automatic test_invalid();
      int seen = 0;
      strobe(1'b1, 3'b111, 1'b0, 7'd0);
      strobe(1'b1, 3'b000, 1'b0, 7'd0);
      repeat (12) begin
         @(negedge clk_3125KHz);
         if (tx.tx_start) seen++;
      end
      checks += 2;
      if (seen != 0) begin
         errors++; $display("FAIL invalid_output: got %0d starts want 0", seen);
      end
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL invalid_overflow: got %b want 0", overflow);
      end
   endtask

   task automatic test_back_to_back();
      strobe(1'b1, 3'b100, 1'b0, 7'd0);
      strobe(1'b0, 3'b000, 1'b1, 7'd42);
      strobe(1'b1, 3'b010, 1'b0, 7'd0);
      strobe(1'b1, 3'b001, 1'b0, 7'd0);
      wait_idle("b2b");
   endtask

   task automatic test_overflow();
      hold_done = 1'b1;
      for (int i = 1; i <= 5; i++) strobe(1'b0, 3'b000, 1'b1, 7'(i));
      repeat (3) @(negedge clk_3125KHz);
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL ovf_early: got %b want 0", overflow);
      end
      node_valid = 1'b1;
      node       = 7'd6;
      @(negedge clk_3125KHz);
      node_valid = 1'b0;
      repeat (3) @(negedge clk_3125KHz);
      checks++;
      if (overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_set: got %b want 1", overflow);
      end
      hold_done = 1'b0;
      wait_idle("ovf");
      checks++;
      if (overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_sticky: got %b want 1", overflow);
      end
   endtask

   task automatic test_reset_mid();
      int cnt  = 0;
      int n    = 0;
      int seen = 0;
      strobe(1'b1, 3'b010, 1'b0, 7'd0);
      while (cnt < 5 && n < 500) begin
         @(negedge clk_3125KHz);
         n++;
         if (tx.tx_start) cnt++;
      end
      checks++;
      if (cnt != 5) begin
         errors++; $display("FAIL mid_reach: got %0d bytes want 5", cnt);
      end
      rst = 1'b1;
      @(negedge clk_3125KHz);
      checks += 4;
      if (tx.tx_start !== 1'b0) begin
         errors++; $display("FAIL mid_tx_start: got %b want 0", tx.tx_start);
      end
      if (tx.msg !== 8'h00) begin
         errors++; $display("FAIL mid_msg: got %h want 00", tx.msg);
      end
      if (busy !== 1'b0) begin
         errors++; $display("FAIL mid_busy: got %b want 0", busy);
      end
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL mid_overflow: got %b want 0", overflow);
      end
      exp_q.delete();
      @(negedge clk_3125KHz);
      rst = 1'b0;
      repeat (30) begin
         @(negedge clk_3125KHz);
         if (tx.tx_start) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL mid_quiet: got %0d starts want 0", seen);
      end
      strobe(1'b1, 3'b100, 1'b0, 7'd0);
      wait_idle("recover");
   endtask

   initial begin
      test_reset();
      test_red_latency();
      test_node();
      test_pair();
      test_invalid();
      test_back_to_back();
      test_overflow();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
